// File: rtl/pipe_skid_buffer_if.sv
// Valid/ready handshake bundle between an upstream stage, the skid buffer and a downstream stage.
// The slave modport is the buffer's view; master is the view of the logic driving it.
interface pipe_skid_buffer_if #(
   parameter int Size = 64
);
   logic            flush;
   logic            valid_i;
   logic            ready_o;
   logic [Size-1:0] data_i;
   logic            valid_o;
   logic            ready_i;
   logic [Size-1:0] data_o;
   logic [1:0]      count_o;

   modport slave (
      input  flush,
      input  valid_i,
      input  data_i,
      input  ready_i,
      output ready_o,
      output valid_o,
      output data_o,
      output count_o
   );

   modport master (
      output flush,
      output valid_i,
      output data_i,
      output ready_i,
      input  ready_o,
      input  valid_o,
      input  data_o,
      input  count_o
   );
endinterface

// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic pipeline register: main register drives data_o, skid register absorbs one
// item when downstream stalls. All handshake outputs are flops, so ready_o has no input path.
module pipe_skid_buffer #(
   parameter int Size = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   pipe_skid_buffer_if.slave     bus
);

   // Encoding equals the number of stored entries, so count_o is the state itself.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [Size-1:0] main_q,  main_d;
   logic [Size-1:0] skid_q,  skid_d;
   logic            valid_q, valid_d;
   logic            ready_q, ready_d;
   logic [1:0]      count_q, count_d;

   logic in_xfer;
   logic out_xfer;

   assign in_xfer  = bus.valid_i && ready_q;
   assign out_xfer = valid_q && bus.ready_i;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      if (bus.flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_xfer) begin
                  main_d  = bus.data_i;
                  state_d = FULL;
               end
            end
            FULL: begin
               if (in_xfer && out_xfer) begin
                  main_d = bus.data_i;
               end else if (in_xfer) begin
                  skid_d  = bus.data_i;
                  state_d = SKID;
               end else if (out_xfer) begin
                  state_d = EMPTY;
               end
            end
            SKID: begin
               if (out_xfer) begin
                  main_d  = skid_q;
                  state_d = FULL;
               end
            end
            default: state_d = EMPTY;
         endcase
      end

      valid_d = (state_d != EMPTY);
      ready_d = (state_d != SKID);
      count_d = state_d;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values and updates together.
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         count_q <= 2'd0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         count_q <= count_d;
      end
   end

   assign bus.valid_o = valid_q;
   assign bus.ready_o = ready_q;
   assign bus.data_o  = main_q;
   assign bus.count_o = count_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed vector table for the skid buffer plus a randomized run against a queue model.
module tb_pipe_skid_buffer;

   localparam int Size = 64;

   logic clk;
   logic reset;

   pipe_skid_buffer_if #(.Size(Size)) bus ();

   pipe_skid_buffer #(.Size(Size)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic        rst;
      logic        flush;
      logic        valid;
      logic [63:0] data;
      logic        ready;
      logic        exp_valid;
      logic        exp_ready;
      logic [1:0]  exp_count;
      logic [63:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string n, input logic r, input logic f, input logic vi,
                               input logic [63:0] d, input logic ri, input logic ev,
                               input logic er, input logic [1:0] ec, input logic [63:0] ed);
      vec_t v;
      v.name = n; v.rst = r; v.flush = f; v.valid = vi; v.data = d; v.ready = ri;
      v.exp_valid = ev; v.exp_ready = er; v.exp_count = ec; v.exp_data = ed;
      return v;
   endfunction

   // Random-phase model state.
   logic [63:0] model_q[$];
   logic [63:0] prev_data;
   logic        prev_stall;

   initial begin
      reset       = 1'b1;
      bus.flush   = 1'b0;
      bus.valid_i = 1'b0;
      bus.data_i  = '0;
      bus.ready_i = 1'b0;

      //                name            rst flush vi  data                    ri  ev  er  cnt   data_o
      vecs.push_back(mk("reset_0",       1, 0,    1, 64'hDEADBEEF_CAFEF00D,  0,  0,  1,  2'd0, 64'h0));
      vecs.push_back(mk("reset_1",       1, 0,    1, 64'hDEADBEEF_CAFEF00D,  0,  0,  1,  2'd0, 64'h0));
      vecs.push_back(mk("stream_1",      0, 0,    1, 64'h1,                  1,  1,  1,  2'd1, 64'h1));
      vecs.push_back(mk("stream_2",      0, 0,    1, 64'h2,                  1,  1,  1,  2'd1, 64'h2));
      vecs.push_back(mk("stream_3",      0, 0,    1, 64'h3,                  1,  1,  1,  2'd1, 64'h3));
      vecs.push_back(mk("stream_drain",  0, 0,    0, 64'h0,                  1,  0,  1,  2'd0, 64'h3));
      vecs.push_back(mk("stall_a",       0, 0,    1, 64'hA,                  0,  1,  1,  2'd1, 64'hA));
      vecs.push_back(mk("stall_b",       0, 0,    1, 64'hB,                  0,  1,  0,  2'd2, 64'hA));
      vecs.push_back(mk("stall_c0",      0, 0,    1, 64'hC,                  0,  1,  0,  2'd2, 64'hA));
      vecs.push_back(mk("stall_c1",      0, 0,    1, 64'hC,                  0,  1,  0,  2'd2, 64'hA));
      vecs.push_back(mk("stall_c2",      0, 0,    1, 64'hC,                  0,  1,  0,  2'd2, 64'hA));
      vecs.push_back(mk("unstall_b",     0, 0,    1, 64'hC,                  1,  1,  1,  2'd1, 64'hB));
      vecs.push_back(mk("unstall_c",     0, 0,    1, 64'hC,                  1,  1,  1,  2'd1, 64'hC));
      vecs.push_back(mk("unstall_drain", 0, 0,    0, 64'h0,                  1,  0,  1,  2'd0, 64'hC));
      vecs.push_back(mk("fl_fill0",      0, 0,    1, 64'h44,                 0,  1,  1,  2'd1, 64'h44));
      vecs.push_back(mk("fl_fill1",      0, 0,    1, 64'h45,                 0,  1,  0,  2'd2, 64'h44));
      vecs.push_back(mk("flush_skid",    0, 1,    1, 64'h55,                 0,  0,  1,  2'd0, 64'h44));
      vecs.push_back(mk("flush_after",   0, 0,    0, 64'h0,                  1,  0,  1,  2'd0, 64'h44));
      vecs.push_back(mk("rs_fill0",      0, 0,    1, 64'h11,                 0,  1,  1,  2'd1, 64'h11));
      vecs.push_back(mk("rs_fill1",      0, 0,    1, 64'h22,                 0,  1,  0,  2'd2, 64'h11));
      vecs.push_back(mk("reset_skid",    1, 0,    1, 64'h99,                 1,  0,  1,  2'd0, 64'h0));
      vecs.push_back(mk("rs_push33",     0, 0,    1, 64'h33,                 1,  1,  1,  2'd1, 64'h33));
      vecs.push_back(mk("rs_drain",      0, 0,    0, 64'h0,                  1,  0,  1,  2'd0, 64'h33));
      vecs.push_back(mk("ff_fill",       0, 0,    1, 64'h66,                 0,  1,  1,  2'd1, 64'h66));
      vecs.push_back(mk("flush_full",    0, 1,    1, 64'h77,                 1,  0,  1,  2'd0, 64'h66));
      vecs.push_back(mk("hold_fill",     0, 0,    1, 64'h88,                 0,  1,  1,  2'd1, 64'h88));
      vecs.push_back(mk("hold_idle",     0, 0,    0, 64'h0,                  0,  1,  1,  2'd1, 64'h88));
      vecs.push_back(mk("hold_drain",    0, 0,    0, 64'h0,                  1,  0,  1,  2'd0, 64'h88));

      // Directed table: drive on the falling edge, sample 1 ns after the rising edge.
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset       = vecs[i].rst;
         bus.flush   = vecs[i].flush;
         bus.valid_i = vecs[i].valid;
         bus.data_i  = vecs[i].data;
         bus.ready_i = vecs[i].ready;
         @(posedge clk);
         #1;
         check({vecs[i].name, ".valid_o"}, 64'(bus.valid_o), 64'(vecs[i].exp_valid));
         check({vecs[i].name, ".ready_o"}, 64'(bus.ready_o), 64'(vecs[i].exp_ready));
         check({vecs[i].name, ".count_o"}, 64'(bus.count_o), 64'(vecs[i].exp_count));
         check({vecs[i].name, ".data_o"},  bus.data_o,       vecs[i].exp_data);
      end

      // Randomized run: the table ended with the buffer EMPTY and out of reset.
      model_q.delete();
      prev_stall = 1'b0;
      prev_data  = '0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         logic        m_in;
         logic        m_out;
         logic        r_valid;
         logic        r_ready;
         logic        r_flush;
         logic [63:0] r_data;

         @(negedge clk);
         check("rnd.valid_o", 64'(bus.valid_o), 64'(model_q.size() > 0));
         check("rnd.ready_o", 64'(bus.ready_o), 64'(model_q.size() < 2));
         check("rnd.count_o", 64'(bus.count_o), 64'(model_q.size()));
         if (model_q.size() > 0) check("rnd.data_o", bus.data_o, model_q[0]);
         if (prev_stall) check("rnd.stable", bus.data_o, prev_data);

         r_valid = ($urandom_range(0, 99) < 70);
         r_ready = ($urandom_range(0, 99) < 60);
         r_flush = ($urandom_range(0, 99) < 2);
         r_data  = {$urandom, $urandom};
         reset       = 1'b0;
         bus.flush   = r_flush;
         bus.valid_i = r_valid;
         bus.data_i  = r_data;
         bus.ready_i = r_ready;

         m_in  = r_valid && (model_q.size() < 2);
         m_out = (model_q.size() > 0) && r_ready;
         prev_stall = (model_q.size() > 0) && !r_ready && !r_flush;
         prev_data  = (model_q.size() > 0) ? model_q[0] : 64'h0;

         @(posedge clk);
         if (r_flush) begin
            model_q.delete();
         end else begin
            if (m_out) void'(model_q.pop_front());
            if (m_in) model_q.push_back(r_data);
         end
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
